// File: rtl/cn_rst_seq.sv
// Power-on reset sequencer: DC-OK delay, staggered per-domain reset release,
// optional BIST with timeout and clear. Abort on pwr_ok loss at any point.
module cn_rst_seq #(
   parameter int NUM_DOM     = 4,
   parameter int DCOK_CYC    = 16,
   parameter int STAGGER_CYC = 8,
   parameter int BIST_TO     = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pwr_ok,
   input  logic               bist_en,
   output logic [NUM_DOM-1:0] dom_dcok,
   output logic [NUM_DOM-1:0] dom_rst_n,
   output logic [NUM_DOM-1:0] start_bist,
   output logic [NUM_DOM-1:0] clear_bist,
   input  logic [NUM_DOM-1:0] bist_complete,
   output logic [NUM_DOM-1:0] bist_fail,
   output logic               seq_done,
   output logic [2:0]         state
);

   localparam int MAX_DS  = (DCOK_CYC > STAGGER_CYC) ? DCOK_CYC : STAGGER_CYC;
   localparam int MAX_CYC = (MAX_DS > BIST_TO) ? MAX_DS : BIST_TO;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
   localparam logic [NUM_DOM-1:0] ALL_ONES = '1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DCOK    = 3'd1,
      S_RELEASE = 3'd2,
      S_BIST    = 3'd3,
      S_CLEAR   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NUM_DOM-1:0] cap_q, cap_d, cap_nxt;
   logic               bist_en_q, bist_en_d;
   logic [NUM_DOM-1:0] dcok_d, rstn_d, start_d, clear_d, fail_d;
   logic               done_d;

   assign state   = state_q;
   assign cap_nxt = cap_q | bist_complete;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      cap_d     = cap_q;
      bist_en_d = bist_en_q;
      dcok_d    = dom_dcok;
      rstn_d    = dom_rst_n;
      start_d   = '0;
      clear_d   = '0;
      fail_d    = bist_fail;
      done_d    = seq_done;

      // Loss of power wins over any in-flight transition; bist_fail is kept
      // so software can still read the last BIST result.
      if (!pwr_ok && state_q != S_IDLE) begin
         state_d = S_IDLE;
         dcok_d  = '0;
         rstn_d  = '0;
         done_d  = 1'b0;
         cap_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pwr_ok) begin
                  bist_en_d = bist_en;
                  fail_d    = '0;
                  cnt_d     = CNT_W'(DCOK_CYC - 1);
                  state_d   = S_DCOK;
               end
            end
            S_DCOK: begin
               if (cnt_q == '0) begin
                  dcok_d  = ALL_ONES;
                  cnt_d   = CNT_W'(STAGGER_CYC - 1);
                  idx_d   = '0;
                  state_d = S_RELEASE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_RELEASE: begin
               if (dom_rst_n[NUM_DOM-1]) begin
                  if (bist_en_q) begin
                     start_d = ALL_ONES;
                     cnt_d   = CNT_W'(BIST_TO - 1);
                     cap_d   = '0;
                     state_d = S_BIST;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end else if (cnt_q == '0) begin
                  rstn_d[idx_q] = 1'b1;
                  idx_d         = idx_q + IDX_W'(1);
                  cnt_d         = CNT_W'(STAGGER_CYC - 1);
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_BIST: begin
               cap_d = cap_nxt;
               // All-complete is checked first so a last-cycle completion is
               // never reported as a timeout.
               if (&cap_nxt || cnt_q == '0) begin
                  fail_d  = ~cap_nxt;
                  clear_d = ALL_ONES;
                  state_d = S_CLEAR;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_CLEAR: begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end
            S_DONE: begin
               done_d = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         cap_q      <= '0;
         bist_en_q  <= 1'b0;
         dom_dcok   <= '0;
         dom_rst_n  <= '0;
         start_bist <= '0;
         clear_bist <= '0;
         bist_fail  <= '0;
         seq_done   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         cap_q      <= cap_d;
         bist_en_q  <= bist_en_d;
         dom_dcok   <= dcok_d;
         dom_rst_n  <= rstn_d;
         start_bist <= start_d;
         clear_bist <= clear_d;
         bist_fail  <= fail_d;
         seq_done   <= done_d;
      end
   end

endmodule

// File: doc/cn_rst_seq.md
CN_RST_SEQ -- requirements
Module: cn_rst_seq

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_DOM, default 4, number of reset domains; legal range 1..16.
REQ-002 The block SHALL have parameter DCOK_CYC, default 16, cycles from pwr_ok sampled high to dom_dcok assertion; must be at least 1.
REQ-003 The block SHALL have parameter STAGGER_CYC, default 8, cycles between successive domain reset releases; must be at least 1.
REQ-004 The block SHALL have parameter BIST_TO, default 1024, BIST timeout in cycles; must be at least 1.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port pwr_ok, input, 1, level request to run the sequence; deassertion aborts.
REQ-008 The block SHALL have port bist_en, input, 1, sampled on the IDLE exit edge.
REQ-009 The block SHALL have port dom_dcok, output, NUM_DOM, DC-OK per domain.
REQ-010 The block SHALL have port dom_rst_n, output, NUM_DOM, active-low reset per domain.
REQ-011 The block SHALL have port start_bist, output, NUM_DOM, one-cycle BIST start pulse per domain.
REQ-012 The block SHALL have port clear_bist, output, NUM_DOM, one-cycle BIST clear pulse per domain.
REQ-013 The block SHALL have port bist_complete, input, NUM_DOM, BIST done per domain; may be a pulse or a level.
REQ-014 The block SHALL have port bist_fail, output, NUM_DOM, per-domain BIST timeout flag.
REQ-015 The block SHALL have port seq_done, output, 1, sequence complete.
REQ-016 The block SHALL have port state, output, 3, current FSM state encoding.

Function
REQ-017 The FSM SHALL have states IDLE=0, DCOK=1, RELEASE=2, BIST=3, CLEAR=4, DONE=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-018 IDLE: when pwr_ok is sampled high at edge E0, the FSM SHALL latch bist_en, clear bist_fail, load the counter with DCOK_CYC-1, and enter DCOK.
REQ-019 DCOK: the counter SHALL decrement each cycle; dom_dcok SHALL go to all-ones at edge E0+DCOK_CYC; the FSM SHALL then load STAGGER_CYC-1, set the domain index to 0, and enter RELEASE.
REQ-020 RELEASE: dom_rst_n[i] SHALL rise at edge E0+DCOK_CYC+(i+1)*STAGGER_CYC and stay high; releases SHALL be in index order, one bit per event.
REQ-021 After dom_rst_n[NUM_DOM-1] rises, the next edge SHALL enter BIST if latched bist_en=1, otherwise DONE.
REQ-022 BIST entry: start_bist SHALL be all-ones for exactly one cycle, and the counter SHALL load BIST_TO-1.
REQ-023 In BIST, a sticky per-domain capture register SHALL set on any cycle where bist_complete[i]=1.
REQ-024 BIST SHALL exit when all capture bits are set or the counter reaches 0 (all-set takes priority in the same cycle); on exit, bist_fail SHALL be set to ~capture and the FSM SHALL enter CLEAR.
REQ-025 CLEAR: clear_bist SHALL be all-ones for exactly one cycle, then the FSM SHALL enter DONE.
REQ-026 DONE: seq_done SHALL be 1 and all other outputs SHALL hold.
REQ-027 Abort: pwr_ok sampled low in any state other than IDLE SHALL, on that edge, drive dom_rst_n=0, dom_dcok=0, start_bist=0, clear_bist=0, seq_done=0, clear the capture register, and enter IDLE; bist_fail SHALL hold.
REQ-028 Abort SHALL take priority over every other transition in the same cycle.
REQ-029 Re-raising pwr_ok after an abort SHALL restart the full sequence from the DCOK delay.
REQ-030 Counter width SHALL be $clog2(max(DCOK_CYC, STAGGER_CYC, BIST_TO)+1); the counter SHALL never wrap (it reloads before reaching 0-1).
REQ-031 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-032 rst_n low SHALL immediately (asynchronously) force state=IDLE and dom_dcok=0, dom_rst_n=0, start_bist=0, clear_bist=0, bist_fail=0, seq_done=0, counter=0, capture=0, and the latched bist_en=0.
REQ-033 On rst_n deassertion, the block SHALL start from IDLE and sample pwr_ok on the first edge.

Verification
REQ-034 Defaults, pwr_ok high at E0, bist_en=0 -> dom_dcok=4'hF at E16; dom_rst_n bits rise at E24, E32, E40, E48; seq_done=1 at E49.
REQ-035 bist_en=1, bist_complete=4'hF 10 cycles after the start_bist pulse -> one-cycle clear_bist=4'hF, bist_fail=4'h0, then seq_done=1.
REQ-036 bist_en=1, bist_complete[2] never asserted -> after 1024 BIST cycles bist_fail=4'b0100, clear_bist pulses, seq_done=1.
REQ-037 bist_complete bits given as single-cycle pulses at different times -> all are captured, no timeout, bist_fail=0.
REQ-038 pwr_ok dropped in RELEASE after 2 domains released -> the next edge gives dom_rst_n=0, dom_dcok=0, state=0; re-raising pwr_ok gives dom_dcok 16 cycles later.
REQ-039 rst_n asserted mid-BIST with clk stopped -> all outputs go to 0 with no clock edge.
